// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with boot, halt/resume and alignment fault
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             halt_req,
    input  logic             resume,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic [1:0]       state,
    output logic             fault,
    output logic [31:0]      fault_addr,
    output logic [CNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    state_t           state_q;
    logic [31:0]      pc_q;
    logic [31:0]      fault_addr_q;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      jump_pc_d;
    logic             misaligned_d;

    // Next-value helpers: saturating redirect count, region-preserving jump target, alignment test
    always_comb begin
        cnt_d        = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        jump_pc_d    = {pc_plus4[31:28], jump_index, 2'b00};
        misaligned_d = (branch_target[1:0] != 2'b00);
    end

    // Sequencer FSM: owns pc, state, fault capture and redirect counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // First fetch at RESET_PC happens in the first RUN cycle
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (jump) begin
                            pc_q  <= jump_pc_d;
                            cnt_q <= cnt_d;
                            if (halt_req) state_q <= ST_HALTED;
                        end else if (branch && misaligned_d) begin
                            // Fault wins over halt; pc stays on the faulting instruction
                            state_q      <= ST_FAULT;
                            fault_q      <= 1'b1;
                            fault_addr_q <= branch_target;
                        end else begin
                            if (branch) begin
                                pc_q  <= branch_target;
                                cnt_q <= cnt_d;
                            end else begin
                                pc_q <= pc_plus4;
                            end
                            if (halt_req) state_q <= ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) state_q <= ST_RUN;
                end
                default: begin
                    // FAULT is sticky until reset
                end
            endcase
        end
    end

    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;
    assign fetch_valid    = (state_q == ST_RUN) && !stall;
    assign state          = state_q;
    assign fault          = fault_q;
    assign fault_addr     = fault_addr_q;
    assign redirect_count = cnt_q;

endmodule
